data_convert_button: RTL

DATA_CONVERT_BUTTON -- requirements
Module: data_convert_button

---
 rtl/data_convert_button.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/data_convert_button.sv
// Button-code to one-hot pulse converter: 1-cycle latency from write to buttonOut, PULSE_LEN high, GAP_LEN idle.
// Codes offered while the buffer is full (and not popping) are dropped; define DATA_CONVERT_BUTTON_FIFO_EN for a 4-deep FIFO.
module data_convert_button #(
  parameter int unsigned PULSE_LEN = 2,
  parameter int unsigned GAP_LEN   = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] dataIn,
  input  logic       dataValid,
  output logic [3:0] buttonOut,
  output logic       busy,
  output logic       full,
  output logic       dataDrop
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [3:0] out_q, out_d;
  logic       drop_q, drop_d;
  logic       pop, push, buf_empty, buf_full;
  logic [1:0] head;

  // A pop frees a slot on the same edge, so a full buffer can still accept.
  assign push   = dataValid && (!buf_full || pop);
  assign drop_d = dataValid && !push;

`ifdef DATA_CONVERT_BUTTON_FIFO_EN
  logic [1:0] mem_q [4];
  logic [1:0] rd_ptr_q, wr_ptr_q;
  logic [2:0] cnt_q;

  assign buf_empty = (cnt_q == 3'd0);
  assign buf_full  = (cnt_q == 3'd4);
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      cnt_q <= cnt_q + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= dataIn;
  end
`else
  logic [1:0] hold_q;
  logic       hold_vld_q;

  assign buf_empty = !hold_vld_q;
  assign buf_full  = hold_vld_q;
  assign head      = hold_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_q     <= 2'd0;
      hold_vld_q <= 1'b0;
    end else if (push) begin
      hold_q     <= dataIn;
      hold_vld_q <= 1'b1;
    end else if (pop) begin
      hold_vld_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= 8'd0;
      out_q   <= 4'b0000;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
    end
  end

  // Emptiness is sampled from registered state, so a same-edge write is only seen next edge.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!buf_empty) begin
          pop     = 1'b1;
          state_d = PULSE;
          count_d = 8'(PULSE_LEN - 1);
        end
      end
      PULSE: begin
        if (count_q == 8'd0) begin
          state_d = GAP;
          count_d = 8'(GAP_LEN - 1);
        end else begin
          count_d = count_q - 8'd1;
        end
      end
      GAP: begin
        if (count_q == 8'd0) begin
          if (!buf_empty) begin
            pop     = 1'b1;
            state_d = PULSE;
            count_d = 8'(PULSE_LEN - 1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          count_d = count_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    out_d = 4'b0000;
    if (pop) begin
      out_d = 4'b0001 << head;
    end else if (state_d == PULSE) begin
      out_d = out_q;
    end
  end

  assign buttonOut = out_q;
  assign dataDrop  = drop_q;
  assign full      = buf_full;
  assign busy      = (state_q != IDLE) || !buf_empty;

endmodule
